// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: pipeline stream and MDU share one RF write port.
// Pipeline has priority; a starvation FSM raises stall_req to drain it.
module wb_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWrite,
   input  logic        MEMtoReg,
   input  logic [31:0] RD_in,
   input  logic [31:0] ALU_result_in,
   input  logic [4:0]  regdst_in,
   input  logic        mdu_req,
   input  logic [4:0]  mdu_dst,
   input  logic [31:0] mdu_data,
   output logic        mdu_ack,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        stall_req
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FORCE = 2'd2
   } state_t;

   localparam logic [3:0] LIMIT4 = 4'(STARVE_LIMIT);
   localparam logic [4:0] LIMIT5 = 5'(STARVE_LIMIT);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic [4:0]  w_cnt_inc;
   logic        r_stall;
   logic        w_pipe_wr;
   logic        w_mdu_wr;
   logic        w_denied;
   logic        w_release;
   logic [31:0] w_pipe_data;

   assign w_pipe_wr   = RegWrite & (regdst_in != 5'd0);
   assign w_pipe_data = MEMtoReg ? RD_in : ALU_result_in;
   assign w_mdu_wr    = mdu_req & (mdu_dst != 5'd0);
   assign w_denied    = mdu_req & ~mdu_ack;
   assign w_release   = mdu_ack | ~mdu_req;
   assign w_cnt_inc   = {1'b0, r_cnt} + 5'd1;
   assign stall_req   = r_stall;

   // Write-port grant; everything is held at zero while reset is active
   always_comb begin
      mdu_ack  = 1'b0;
      rf_we    = 1'b0;
      rf_waddr = 5'd0;
      rf_wdata = 32'd0;
      if (!rst) begin
         if (w_pipe_wr) begin
            rf_we    = 1'b1;
            rf_waddr = regdst_in;
            rf_wdata = w_pipe_data;
         end else if (mdu_req) begin
            mdu_ack  = 1'b1;
            rf_we    = w_mdu_wr;
            rf_waddr = mdu_dst;
            rf_wdata = mdu_data;
         end
      end
   end

   // Starvation counter next value, saturating at the limit
   always_comb begin
      w_cnt_nxt = 4'd0;
      if (w_denied) begin
         w_cnt_nxt = (r_cnt == LIMIT4) ? r_cnt : w_cnt_inc[3:0];
      end
   end

   // Starvation FSM next state
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_denied) begin
               w_state_nxt = (STARVE_LIMIT == 1) ? FORCE : WAIT;
            end
         end
         WAIT: begin
            if (w_release) begin
               w_state_nxt = IDLE;
            end else if (w_cnt_inc == LIMIT5) begin
               w_state_nxt = FORCE;
            end
         end
         FORCE: begin
            if (w_release) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, counter and registered stall request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_stall <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_stall <= (w_state_nxt == FORCE);
      end
   end

endmodule
